// File: rtl/onp_sequencer.sv
// Token-driven sequencer for one RPN stack calculator: turns accepted tokens
// into step/push/d/op strobes, checks stack depth and reports one result per expression.
module onp_sequencer #(
  parameter int DW    = 16,
  parameter int CW    = 10,
  parameter int DEPTH = 1023
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [1:0]    tok_kind,
  input  logic [DW-1:0] tok_data,
  input  logic [1:0]    tok_op,
  output logic          onp_nrst,
  output logic          onp_step,
  output logic          onp_push,
  output logic [DW-1:0] onp_d,
  output logic [1:0]    onp_op,
  input  logic [DW-1:0] onp_out,
  input  logic [CW-1:0] onp_cnt,
  output logic          busy,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          res_err,
  output logic [2:0]    err_code
);

  // state  | meaning
  // CLR    | calculator held in reset for one cycle, sticky error cleared
  // IDLE   | waiting for a token, depth checked against onp_cnt
  // SETUP  | push/d/op driven, step low
  // STROBE | step high, calculator registers update
  // HOLD   | step low again, push/d/op held
  // DRAIN  | error seen, discard tokens until end of expression
  // DONE   | one-cycle result pulse
  typedef enum logic [2:0] {
    S_CLR, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DRAIN, S_DONE
  } state_t;

  localparam logic [1:0]    K_PUSH  = 2'd0;
  localparam logic [1:0]    K_OP    = 2'd1;
  localparam logic [1:0]    K_END   = 2'd2;
  localparam logic [2:0]    E_OK    = 3'd0;
  localparam logic [2:0]    E_UNDER = 3'd1;
  localparam logic [2:0]    E_OVER  = 3'd2;
  localparam logic [2:0]    E_ILL   = 3'd3;
  localparam logic [2:0]    E_DEPTH = 3'd4;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(2);

  state_t        state_q, state_d;
  logic          onp_nrst_q, onp_nrst_d;
  logic          onp_step_q, onp_step_d;
  logic          onp_push_q, onp_push_d;
  logic [DW-1:0] onp_d_q, onp_d_d;
  logic [1:0]    onp_op_q, onp_op_d;
  logic          tok_ready_q, tok_ready_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [2:0]    sticky_q, sticky_d;

  logic          accept;
  logic [CW-1:0] need;

  assign accept = tok_valid && tok_ready_q;
  assign need   = tok_op[1] ? CNT_TWO : CNT_ONE;

  always_comb begin
    state_d    = state_q;
    onp_push_d = onp_push_q;
    onp_d_d    = onp_d_q;
    onp_op_d   = onp_op_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    err_code_d = err_code_q;
    sticky_d   = sticky_q;

    case (state_q)
      S_CLR: begin
        sticky_d = E_OK;
        state_d  = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          case (tok_kind)
            K_PUSH: begin
              if (onp_cnt == CNT_MAX) begin
                sticky_d = E_OVER;
                state_d  = S_DRAIN;
              end else begin
                onp_d_d    = tok_data;
                onp_push_d = 1'b1;
                state_d    = S_SETUP;
              end
            end
            K_OP: begin
              if (onp_cnt < need) begin
                sticky_d = E_UNDER;
                state_d  = S_DRAIN;
              end else begin
                onp_op_d   = tok_op;
                onp_push_d = 1'b0;
                state_d    = S_SETUP;
              end
            end
            K_END: begin
              res_data_d = onp_out;
              res_err_d  = (onp_cnt != CNT_ONE);
              err_code_d = (onp_cnt != CNT_ONE) ? E_DEPTH : E_OK;
              state_d    = S_DONE;
            end
            default: begin
              sticky_d = E_ILL;
              state_d  = S_DRAIN;
            end
          endcase
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_IDLE;
      S_DRAIN: begin
        if (accept && tok_kind == K_END) begin
          res_err_d  = 1'b1;
          res_data_d = onp_out;
          err_code_d = sticky_q;
          state_d    = S_DONE;
        end
      end
      S_DONE:   state_d = S_CLR;
      default:  state_d = S_CLR;
    endcase

    // Every output is a registered decode of the state being entered.
    onp_nrst_d  = (state_d != S_CLR);
    onp_step_d  = (state_d == S_STROBE);
    tok_ready_d = (state_d == S_IDLE) || (state_d == S_DRAIN);
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_CLR;
      onp_nrst_q  <= 1'b0;
      onp_step_q  <= 1'b0;
      onp_push_q  <= 1'b0;
      onp_d_q     <= '0;
      onp_op_q    <= '0;
      tok_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      err_code_q  <= E_OK;
      sticky_q    <= E_OK;
    end else begin
      state_q     <= state_d;
      onp_nrst_q  <= onp_nrst_d;
      onp_step_q  <= onp_step_d;
      onp_push_q  <= onp_push_d;
      onp_d_q     <= onp_d_d;
      onp_op_q    <= onp_op_d;
      tok_ready_q <= tok_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      err_code_q  <= err_code_d;
      sticky_q    <= sticky_d;
    end
  end

  assign tok_ready = tok_ready_q;
  assign onp_nrst  = onp_nrst_q;
  assign onp_step  = onp_step_q;
  assign onp_push  = onp_push_q;
  assign onp_d     = onp_d_q;
  assign onp_op    = onp_op_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_onp_sequencer.sv
// Bench for onp_sequencer: behavioural calculator, expression-level reference
// model, scoreboard queue checked by an independent result monitor.
module tb_onp_sequencer;

  localparam int DW    = 16;
  localparam int CW    = 10;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]    kind;
    logic [DW-1:0] data;
    logic [1:0]    op;
  } tok_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic [2:0]    code;
    logic [7:0]    steps;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          tok_valid;
  logic          tok_ready;
  logic [1:0]    tok_kind;
  logic [DW-1:0] tok_data;
  logic [1:0]    tok_op;
  logic          onp_nrst;
  logic          onp_step;
  logic          onp_push;
  logic [DW-1:0] onp_d;
  logic [1:0]    onp_op;
  logic [DW-1:0] onp_out;
  logic [CW-1:0] onp_cnt;
  logic          busy;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_err;
  logic [2:0]    err_code;

  onp_sequencer #(.DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind),
    .tok_data(tok_data), .tok_op(tok_op),
    .onp_nrst(onp_nrst), .onp_step(onp_step), .onp_push(onp_push),
    .onp_d(onp_d), .onp_op(onp_op), .onp_out(onp_out), .onp_cnt(onp_cnt),
    .busy(busy), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Behavioural calculator: registers clocked by onp_step, cleared by onp_nrst.
  logic signed [DW-1:0] cstk [0:1023];
  int csp;
  always @(posedge onp_step or negedge onp_nrst) begin
    if (!onp_nrst) csp <= 0;
    else if (onp_push) begin
      if (csp < 1023) begin
        cstk[csp] <= onp_d;
        csp <= csp + 1;
      end
    end else begin
      case (onp_op)
        2'd1: if (csp >= 1) cstk[csp-1] <= -cstk[csp-1];
        2'd2: if (csp >= 2) begin
          cstk[csp-2] <= cstk[csp-2] + cstk[csp-1];
          csp <= csp - 1;
        end
        2'd3: if (csp >= 2) begin
          cstk[csp-2] <= cstk[csp-2] * cstk[csp-1];
          csp <= csp - 1;
        end
        default: ;
      endcase
    end
  end
  assign onp_cnt = CW'(csp);
  assign onp_out = (csp > 0) ? cstk[csp-1] : '0;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   last_acc;
  bit   last_iss;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic tok_t mk(input int kind, input int val);
    tok_t t;
    t.kind = 2'(kind);
    t.data = DW'(val);
    t.op   = (kind == 1) ? 2'(val) : 2'd0;
    return t;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with tok_valid still high.
  task automatic send_tok(input tok_t t, input bit iss);
    int n = 0;
    tok_valid = 1'b1;
    tok_kind  = t.kind;
    tok_data  = t.data;
    tok_op    = t.op;
    while (!tok_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
    end else begin
      if (last_iss) chk("accept_gap", 64'(cyc - last_acc), 64'd4);
      last_acc = cyc;
      last_iss = iss;
    end
    @(negedge clk);
  endtask

  // Expression-level reference: evaluate with a queue, stop issuing at the first error.
  task automatic run_expr(input tok_t e[$]);
    logic signed [DW-1:0] st[$];
    logic signed [DW-1:0] a;
    bit   iss[$];
    int   err = 0;
    int   steps = 0;
    exp_t ex;
    foreach (e[i]) begin
      iss.push_back(1'b0);
      if (e[i].kind == 2'd2 || err != 0) continue;
      case (e[i].kind)
        2'd0: if (st.size() == DEPTH) err = 2;
              else begin st.push_back(e[i].data); iss[i] = 1'b1; end
        2'd1: if (st.size() < ((e[i].op >= 2'd2) ? 2 : 1)) err = 1;
              else begin
                iss[i] = 1'b1;
                case (e[i].op)
                  2'd1: st[st.size()-1] = -st[st.size()-1];
                  2'd2: begin a = st.pop_back(); st[st.size()-1] = st[st.size()-1] + a; end
                  2'd3: begin a = st.pop_back(); st[st.size()-1] = st[st.size()-1] * a; end
                  default: ;
                endcase
              end
        default: err = 3;
      endcase
      if (iss[i]) steps++;
    end
    ex.data  = (st.size() > 0) ? st[st.size()-1] : '0;
    ex.err   = (err != 0) || (st.size() != 1);
    ex.code  = (err != 0) ? 3'(err) : ((st.size() != 1) ? 3'd4 : 3'd0);
    ex.steps = 8'(steps);
    exp_q.push_back(ex);
    last_iss = 1'b0;
    foreach (e[i]) send_tok(e[i], iss[i]);
    tok_valid = 1'b0;
  endtask

  // Result monitor: counts step pulses, pops the scoreboard on every res_valid.
  initial begin
    int   steps = 0;
    bit   chk_clr = 1'b0;
    exp_t ex;
    forever begin
      @(negedge clk);
      if (chk_clr) begin
        chk("onp_nrst_after_done", 64'(onp_nrst), 64'd0);
        chk_clr = 1'b0;
      end
      if (!nrst) steps = 0;
      else if (onp_step) steps++;
      if (nrst && res_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_res_valid", 64'd1, 64'd0);
        end else begin
          ex = exp_q.pop_front();
          chk("res_data", 64'(res_data), 64'(ex.data));
          chk("res_err", 64'(res_err), 64'(ex.err));
          chk("err_code", 64'(err_code), 64'(ex.code));
          chk("step_count", 64'(steps), 64'(ex.steps));
        end
        steps = 0;
        chk_clr = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tok_t e[$];
    int   n;
    nrst = 1'b1; tok_valid = 1'b0; tok_kind = 2'd0; tok_data = '0; tok_op = 2'd0;
    last_acc = 0; last_iss = 1'b0;
    #3 nrst = 1'b0;
    #1;
    chk("rst_onp_nrst", 64'(onp_nrst), 64'd0);
    chk("rst_onp_step", 64'(onp_step), 64'd0);
    chk("rst_tok_ready", 64'(tok_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res", 64'({res_data, res_err, err_code}), 64'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    e = '{mk(0,2), mk(0,3), mk(1,2), mk(0,4), mk(1,3), mk(2,0)};  run_expr(e);
    e = '{mk(0,5), mk(1,2), mk(0,1), mk(2,0)};                    run_expr(e);
    e = '{mk(0,-7), mk(1,1), mk(2,0)};                            run_expr(e);
    e = '{mk(0,1), mk(0,2), mk(2,0)};                             run_expr(e);
    e = '{mk(0,1), mk(0,2), mk(0,3), mk(0,4), mk(0,5), mk(2,0)};  run_expr(e);
    e = '{mk(3,0), mk(0,9), mk(2,0)};                             run_expr(e);
    e = '{mk(2,0)};                                               run_expr(e);

    // Abort mid-expression while the step strobe is high.
    last_iss = 1'b0;
    send_tok(mk(0,1), 1'b1);
    tok_valid = 1'b0;
    n = 0;
    while (!onp_step && n < 20) begin @(negedge clk); n++; end
    chk("reach_strobe", 64'(onp_step), 64'd1);
    nrst = 1'b0;
    #1;
    chk("abort_step", 64'(onp_step), 64'd0);
    chk("abort_onp_nrst", 64'(onp_nrst), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    chk("abort_no_result", 64'(res_valid), 64'd0);
    nrst = 1'b1;
    @(negedge clk);
    e = '{mk(0,1), mk(2,0)};                                      run_expr(e);

    for (int x = 0; x < 60; x++) begin
      int len = $urandom_range(1, 8);
      e.delete();
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 15);
        int v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) - 20 : int'($urandom);
        if (r < 8)       e.push_back(mk(0, v));
        else if (r < 15) e.push_back(mk(1, $urandom_range(0, 3)));
        else             e.push_back(mk(3, 0));
      end
      e.push_back(mk(2, 0));
      run_expr(e);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("results_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
